// File: rtl/pdp8l_iot_seq.sv
// PDP-8/L IOT bus initiator: runs one IOT as start/wait/stop/gap bus cycle.
// Ports: CLOCK/RESET/CSTEP, iot_* CPU side, iop*/ioopcode/cputodev/devtocpu/
// AC_CLEAR/IO_SKIP bus side, arm* register port.
// Optional trace ring: define IOTSEQ_TRACE_EN.
module pdp8l_iot_seq #(
  parameter int IOPWID     = 4,
  parameter int GAPWID     = 2,
  parameter int TRACEDEPTH = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        iot_start,
  input  logic [11:0] iot_instr,
  input  logic [11:0] iot_ac,
  output logic        iot_busy,
  output logic        iot_done,
  output logic [11:0] iot_newac,
  output logic        iot_skip,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  input  logic [11:0] devtocpu,
  input  logic        AC_CLEAR,
  input  logic        IO_SKIP,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata
);

  localparam int TW = $clog2(TRACEDEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_STOP, S_GAP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [11:0] res_ac;
  logic        res_skip;
  logic        res_clr;
  logic        overrun;
  logic [15:0] iotcount;
  logic        is_iot;
  logic        bus_done;
  logic [TW-1:0] tptr;
  logic [31:0] trace_rd;

  assign is_iot   = (iot_instr[11:9] == 3'o6);
  assign bus_done = CSTEP && (state == S_GAP) && (cnt == 4'd0);
  assign iot_busy = (state != S_IDLE);

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (CSTEP) begin
      unique case (state)
        S_IDLE:  if (iot_start && is_iot) state_nx = S_START;
        S_START: state_nx = S_WAIT;
        S_WAIT:  if (cnt == 4'd0) state_nx = S_STOP;
        S_STOP:  state_nx = S_GAP;
        S_GAP:   if (cnt == 4'd0) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt       <= '0;
      iopstart  <= 1'b0;
      iopstop   <= 1'b0;
      iot_done  <= 1'b0;
      ioopcode  <= '0;
      cputodev  <= '0;
      iot_newac <= '0;
      iot_skip  <= 1'b0;
      res_ac    <= '0;
      res_skip  <= 1'b0;
      res_clr   <= 1'b0;
      iotcount  <= '0;
    end else begin
      // pulses last one clock even if CSTEP drops
      iopstart <= 1'b0;
      iopstop  <= 1'b0;
      iot_done <= 1'b0;
      if (CSTEP) begin
        unique case (state)
          S_IDLE: begin
            if (iot_start && !is_iot) begin
              iot_done  <= 1'b1;
              iot_newac <= iot_ac;
              iot_skip  <= 1'b0;
            end else if (iot_start) begin
              ioopcode <= iot_instr;
              cputodev <= iot_ac;
              iopstart <= 1'b1;
            end
          end
          S_START: cnt <= 4'(IOPWID);
          S_WAIT: begin
            if (cnt == 4'd0) begin
              res_ac   <= AC_CLEAR ? devtocpu
                                   : (cputodev | devtocpu);
              res_skip <= IO_SKIP;
              res_clr  <= AC_CLEAR;
              iopstop  <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_STOP: cnt <= 4'(GAPWID);
          S_GAP: begin
            if (cnt == 4'd0) begin
              ioopcode  <= '0;
              cputodev  <= '0;
              iot_done  <= 1'b1;
              iot_newac <= res_ac;
              iot_skip  <= res_skip;
              iotcount  <= iotcount + 16'd1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // set wins over a simultaneous software clear
  always_ff @(posedge CLOCK) begin
    if (RESET) overrun <= 1'b0;
    else if (iot_start && iot_busy) overrun <= 1'b1;
    else if (armwrite && armwaddr == 2'd1 && armwdata[31])
      overrun <= 1'b0;
  end

`ifdef IOTSEQ_TRACE_EN
  logic [23:0]   ring [TRACEDEPTH];
  logic [TW-1:0] wptr;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr <= '0;
      tptr <= '0;
      for (int i = 0; i < TRACEDEPTH; i++) ring[i] <= '0;
    end else begin
      if (bus_done) begin
        ring[wptr] <= {1'b1, res_skip, res_clr,
                       ioopcode[8:0], res_ac};
        wptr <= wptr + 1'b1;
      end
      if (armwrite && armwaddr == 2'd3)
        tptr <= armwdata[TW-1:0];
    end
  end

  assign trace_rd = 32'(ring[tptr]);
`else
  assign tptr     = '0;
  assign trace_rd = 32'd0;
`endif

  logic unused_ok;
  assign unused_ok = ^{armwdata, res_clr, bus_done};

  always_comb begin
    armrdata = 32'd0;
    unique case (armraddr)
      2'd0: armrdata = 32'h4953_1008;
      2'd1: armrdata = {iot_busy, overrun, 14'b0, iotcount};
      2'd2: armrdata = trace_rd;
      2'd3: armrdata = 32'(tptr);
      default: armrdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pdp8l_iot_seq.sv
// Scoreboard bench for pdp8l_iot_seq: directed bus scenarios
// plus randomized IOTs checked against a reference model.
module tb_pdp8l_iot_seq;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        CSTEP = 1'b1;
  logic        iot_start = 1'b0;
  logic [11:0] iot_instr = '0;
  logic [11:0] iot_ac = '0;
  logic [11:0] devtocpu = '0;
  logic        AC_CLEAR = 1'b0;
  logic        IO_SKIP = 1'b0;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = '0;
  logic [1:0]  armwaddr = '0;
  logic [31:0] armwdata = '0;
  logic        iot_busy, iot_done, iot_skip;
  logic        iopstart, iopstop;
  logic [11:0] iot_newac, ioopcode, cputodev;
  logic [31:0] armrdata;

  pdp8l_iot_seq dut (
    .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP),
    .iot_start(iot_start), .iot_instr(iot_instr),
    .iot_ac(iot_ac), .iot_busy(iot_busy),
    .iot_done(iot_done), .iot_newac(iot_newac),
    .iot_skip(iot_skip), .iopstart(iopstart),
    .iopstop(iopstop), .ioopcode(ioopcode),
    .cputodev(cputodev), .devtocpu(devtocpu),
    .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP),
    .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata),
    .armrdata(armrdata)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] ac;
    logic        sk;
    int          dc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int bus_s = 0;
  int stall = 0;
  int nbus = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, a, e, cyc);
    end
  endtask

  exp_t me;
  always @(negedge CLOCK) begin
    if (iot_done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = q.pop_front();
        chk("newac", 32'(iot_newac), 32'(me.ac));
        chk("skip", 32'(iot_skip), 32'(me.sk));
        chk("done_cycle", cyc, me.dc);
      end
    end
    if (iopstart) chk("iopstart_cycle", cyc, bus_s + 1);
    if (iopstop)  chk("iopstop_cycle", cyc, bus_s + 7 + stall);
    if (iopstart || iopstop)
      chk("pulse_overlap", 32'(iopstart & iopstop), 0);
  end

  task automatic issue(input logic [11:0] ins,
                       input logic [11:0] ac,
                       input logic [11:0] dv,
                       input logic cl, input logic sk);
    int n;
    logic bus;
    exp_t e;
    n = 0;
    @(negedge CLOCK);
    while (iot_busy && n < 300) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 300) chk("issue_timeout", 1, 0);
    bus = (ins[11:9] == 3'o6);
    iot_instr = ins;
    iot_ac    = ac;
    devtocpu  = dv;
    AC_CLEAR  = cl;
    IO_SKIP   = sk;
    iot_start = 1'b1;
    if (bus) begin
      e.ac = cl ? dv : (ac | dv);
      e.sk = sk;
      e.dc = cyc + 11 + stall;
      bus_s = cyc;
      nbus++;
    end else begin
      e.ac = ac;
      e.sk = 1'b0;
      e.dc = cyc + 1;
    end
    q.push_back(e);
    @(negedge CLOCK);
    iot_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLOCK);
    while ((q.size() != 0 || iot_busy) && n < 300) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  task automatic arm_rd(input logic [1:0] a,
                        output logic [31:0] d);
    armraddr = a;
    #1 d = armrdata;
  endtask

  task automatic arm_wr(input logic [1:0] a,
                        input logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1'b1;
    armwaddr = a;
    armwdata = d;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  logic [31:0] texp;
  int bad;
  logic [11:0] ri, ra, rd;

  initial begin
    repeat (2) @(negedge CLOCK);
    chk("rst_busy", 32'(iot_busy), 0);
    chk("rst_done", 32'(iot_done), 0);
    chk("rst_newac", 32'(iot_newac), 0);
    chk("rst_iopstart", 32'(iopstart), 0);
    chk("rst_opcode", 32'(ioopcode), 0);
    arm_rd(2'd0, d);
    chk("ident", d, 32'h4953_1008);
    arm_rd(2'd1, d);
    chk("rst_status", d, 0);
    RESET = 1'b0;

    issue(12'o6031, 12'o0000, 12'o0000, 1'b0, 1'b1);
    wait_idle();
    issue(12'o6036, 12'o7777, 12'o0101, 1'b1, 1'b0);
    wait_idle();

    issue(12'o7200, 12'o4321, 12'o0077, 1'b1, 1'b1);
    wait_idle();
    arm_rd(2'd1, d);
    chk("iotcount_nonbus", 32'(d[15:0]), 32'(nbus));

    // reset in the middle of WAIT
    issue(12'o6031, 12'o0011, 12'o0000, 1'b0, 1'b1);
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("midrst_busy", 32'(iot_busy), 0);
    chk("midrst_iopstart", 32'(iopstart), 0);
    chk("midrst_iopstop", 32'(iopstop), 0);
    chk("midrst_opcode", 32'(ioopcode), 0);
    RESET = 1'b0;
    q.delete();
    nbus = 0;

    issue(12'o6046, 12'o0200, 12'o0005, 1'b0, 1'b0);
    wait_idle();
    arm_wr(2'd3, 32'd0);
    arm_rd(2'd2, d);
`ifdef IOTSEQ_TRACE_EN
    texp = 32'({1'b1, 1'b0, 1'b0, 9'o046, 12'o0205});
`else
    texp = 32'd0;
`endif
    chk("trace0", d, texp);

    // overrun: start while busy
    issue(12'o6042, 12'o0003, 12'o0000, 1'b0, 1'b0);
    repeat (2) @(negedge CLOCK);
    iot_start = 1'b1;
    @(negedge CLOCK);
    iot_start = 1'b0;
    arm_rd(2'd1, d);
    chk("overrun_set", 32'(d[30]), 1);
    wait_idle();
    arm_wr(2'd1, 32'h8000_0000);
    arm_rd(2'd1, d);
    chk("overrun_clr", 32'(d[30]), 0);

    // CSTEP freeze for 20 cycles mid-WAIT
    stall = 20;
    issue(12'o6041, 12'o1234, 12'o0010, 1'b0, 1'b1);
    repeat (2) @(negedge CLOCK);
    CSTEP = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge CLOCK);
      if (!iot_busy || iopstart || iopstop || iot_done ||
          ioopcode !== 12'o6041 || cputodev !== 12'o1234)
        bad++;
    end
    chk("freeze_hold", bad, 0);
    CSTEP = 1'b1;
    wait_idle();
    stall = 0;

    for (int i = 0; i < 40; i++) begin
      ri = 12'($urandom);
      if ($urandom_range(0, 3) != 0) ri[11:9] = 3'o6;
      ra = 12'($urandom);
      rd = 12'($urandom);
      issue(ri, ra, rd, 1'($urandom), 1'($urandom));
    end
    wait_idle();
    arm_rd(2'd1, d);
    chk("iotcount_final", 32'(d[15:0]), 32'(nbus));
    chk("final_busy", 32'(d[31]), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
